pla_vector_sweeper: RTL and testbench



---
 rtl/pla_vector_sweeper.sv | 73 +++++++
 tb/tb_pla_vector_sweeper.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pla_vector_sweeper.sv
// pla_vector_sweeper: sweeps all 2^N_IN vectors into a PLA netlist and accumulates onset/mismatch/MISR results (MISR under PLA_SWEEP_MISR_EN)
module pla_vector_sweeper #(
    parameter int          N_IN     = 10,
    parameter int          SIG_W    = 16,
    parameter logic [31:0] SIG_POLY = 32'h1021
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic [N_IN-1:0]   x,
    input  logic              y_in,
    input  logic              exp_in,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     ones_cnt,
    output logic [N_IN:0]     mm_cnt,
    output logic [N_IN-1:0]   first_mm_addr,
    output logic              first_mm_vld,
    output logic [SIG_W-1:0]  signature
);
    // one flop per status output so busy/done come straight from state bits
    typedef enum logic [1:0] {IDLE = 2'b00, SWEEP = 2'b01, DONE = 2'b10} state_t;
    state_t state, nxt;
    logic go, smp, mm;
    assign go    = (state != SWEEP) && start;
    assign smp   = (state == SWEEP) && !stall;
    assign mm    = y_in ^ exp_in;
    assign busy  = state[0];
    assign done  = state[1];
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    // next state: sweep ends on the sample of the all-ones vector
    always_comb begin
        nxt = state;
        if (state == SWEEP) nxt = (smp && x == {N_IN{1'b1}}) ? DONE : SWEEP;
        else if (start)     nxt = SWEEP;
    end
    // address counter and result accumulators
    always_ff @(posedge clk) begin
        if (rst || go) begin
            x             <= '0;
            ones_cnt      <= '0;
            mm_cnt        <= '0;
            first_mm_addr <= '0;
            first_mm_vld  <= 1'b0;
        end else if (smp) begin
            x        <= x + 1'b1;
            ones_cnt <= ones_cnt + (N_IN+1)'(y_in);
            mm_cnt   <= mm_cnt + (N_IN+1)'(mm);
            if (mm && !first_mm_vld) begin
                first_mm_addr <= x;
                first_mm_vld  <= 1'b1;
            end
        end
    end
`ifdef PLA_SWEEP_MISR_EN
    logic [SIG_W-1:0] sig;
    // serial-input MISR over the sampled netlist output
    always_ff @(posedge clk) begin
        if (rst || go) sig <= '0;
        else if (smp)  sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY[SIG_W-1:0] : '0) ^ SIG_W'(y_in);
    end
    assign signature = sig;
`else
    logic unused_poly;
    assign unused_poly = ^SIG_POLY;
    assign signature   = '0;
`endif
endmodule

// File: tb/tb_pla_vector_sweeper.sv
// tb_pla_vector_sweeper: directed checks of sweep timing, counters, stall, reset and restart
module tb_pla_vector_sweeper;
    logic clk = 0, rst = 1, start = 0, stall = 0, y_in, exp_in;
    logic [9:0] x, first_mm_addr;
    logic busy, done, first_mm_vld;
    logic [10:0] ones_cnt, mm_cnt;
    logic [15:0] signature, sig_x0, sig_exp;
    int checks = 0, errors = 0, cyc = 0, mode = 0;

    pla_vector_sweeper dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .x(x),
        .y_in(y_in), .exp_in(exp_in), .busy(busy), .done(done),
        .ones_cnt(ones_cnt), .mm_cnt(mm_cnt), .first_mm_addr(first_mm_addr),
        .first_mm_vld(first_mm_vld), .signature(signature)
    );

    always #5 clk = ~clk;

    // stand-in netlist and golden model
    always_comb begin
        y_in   = (mode != 0) && x[0];
        exp_in = y_in ^ ((mode == 2) && (x == 10'd5 || x == 10'd700));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_x(input int target);
        int n = 0;
        while (x != target[9:0] && n < 2000) begin tick(); n++; end
        chk("wait_x_reached", {22'd0, x}, target);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin tick(); n++; end
        chk("done_seen", {31'd0, done}, 1);
    endtask

    task automatic chk_res(input string t, input int ones, input int mmc, input int fa, input int fv, input logic [15:0] sg);
        chk({t, "_ones"}, {21'd0, ones_cnt}, ones);
        chk({t, "_mm"}, {21'd0, mm_cnt}, mmc);
        chk({t, "_faddr"}, {22'd0, first_mm_addr}, fa);
        chk({t, "_fvld"}, {31'd0, first_mm_vld}, fv);
        chk({t, "_sig"}, {16'd0, signature}, {16'd0, sg});
        chk({t, "_busy"}, {31'd0, busy}, 0);
        chk({t, "_x"}, {22'd0, x}, 0);
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_x"}, {22'd0, x}, 0);
        chk({t, "_busy"}, {31'd0, busy}, 0);
        chk({t, "_done"}, {31'd0, done}, 0);
        chk({t, "_ones"}, {21'd0, ones_cnt}, 0);
        chk({t, "_mm"}, {21'd0, mm_cnt}, 0);
        chk({t, "_fvld"}, {31'd0, first_mm_vld}, 0);
        chk({t, "_faddr"}, {22'd0, first_mm_addr}, 0);
        chk({t, "_sig"}, {16'd0, signature}, 0);
    endtask

    initial begin
        logic [15:0] s = '0;
        for (int i = 0; i < 1024; i++)
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'd0, i[0]};
        sig_x0 = s;
`ifdef PLA_SWEEP_MISR_EN
        sig_exp = sig_x0;
`else
        sig_exp = '0;
`endif
        tick(); tick();
        rst = 0;
        tick();
        chk_reset("rst0");

        mode = 0;
        pulse_start();
        cyc = 0;
        chk("busy_after_start", {31'd0, busy}, 1);
        wait_done();
        chk("len_const0", cyc, 1024);
        chk_res("const0", 0, 0, 0, 0, 16'h0);

        mode = 1;
        pulse_start();
        chk("done_cleared", {31'd0, done}, 0);
        cyc = 0;
        wait_done();
        chk("len_x0", cyc, 1024);
        chk_res("x0", 512, 0, 0, 0, sig_exp);
        stall = 1;
        tick(); tick();
        chk("done_held", {31'd0, done}, 1);
        chk("ones_held", {21'd0, ones_cnt}, 512);
        stall = 0;

        mode = 2;
        pulse_start();
        cyc = 0;
        wait_done();
        chk_res("mm2", 512, 2, 5, 1, sig_exp);

        mode = 1;
        pulse_start();
        cyc = 0;
        wait_x(300);
        stall = 1;
        repeat (5) tick();
        chk("stall_mid_x", {22'd0, x}, 300);
        repeat (5) tick();
        chk("stall_end_x", {22'd0, x}, 300);
        stall = 0;
        wait_done();
        chk("len_stall", cyc, 1034);
        chk_res("stall", 512, 0, 0, 0, sig_exp);

        mode = 2;
        pulse_start();
        wait_x(300);
        rst = 1;
        tick();
        rst = 0;
        chk_reset("midrst");
        pulse_start();
        cyc = 0;
        wait_done();
        chk("len_after_rst", cyc, 1024);
        chk_res("after_rst", 512, 2, 5, 1, sig_exp);

        mode = 1;
        pulse_start();
        cyc = 0;
        wait_x(100);
        pulse_start();
        chk("restart_ignored_x", {22'd0, x}, 101);
        wait_done();
        chk("len_restart", cyc, 1024);
        chk_res("restart", 512, 0, 0, 0, sig_exp);

        start = 1;
        stall = 1;
        tick();
        start = 0;
        chk("done_start_clear_ones", {21'd0, ones_cnt}, 0);
        chk("done_start_busy", {31'd0, busy}, 1);
        tick();
        chk("stall_after_start_x", {22'd0, x}, 0);
        stall = 0;
        cyc = 0;
        wait_done();
        chk("len_repeat", cyc, 1024);
        chk_res("repeat", 512, 0, 0, 0, sig_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
